// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree with a valid bit per level and global stall/backpressure.
// Optional frame accumulator after the tree, compiled in with `define ADDER_TREE_ACC_EN.
module adder_tree_pipe #(
  parameter int IN_W  = 14,
  parameter int N_IN  = 4,
  parameter int ACC_N = 8,
  localparam int LVL   = $clog2(N_IN),
  localparam int SUM_W = IN_W + LVL,
`ifdef ADDER_TREE_ACC_EN
  localparam int OUT_W = SUM_W + $clog2(ACC_N)
`else
  localparam int OUT_W = SUM_W
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  // Bit offset of level j inside the flattened bus of all level registers.
  function automatic int lvl_off(input int j);
    int o;
    o = 0;
    for (int i = 0; i < j; i++) o += (N_IN >> (i + 1)) * (IN_W + i + 1);
    return o;
  endfunction

  localparam int TOT_W    = lvl_off(LVL);
  localparam int LAST_OFF = lvl_off(LVL - 1);

  if (N_IN < 2 || N_IN > 16 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
    $error("adder_tree_pipe: N_IN must be a power of two in 2..16");
  end
  if (ACC_N < 2 || ACC_N > 256 || (ACC_N & (ACC_N - 1)) != 0) begin : g_bad_acc_n
    $error("adder_tree_pipe: ACC_N must be a power of two in 2..256");
  end

  logic [TOT_W-1:0] w_lvl;
  logic [LVL-1:0]   w_vld;
  logic [SUM_W-1:0] w_tree_sum;
  logic             w_tree_vld;
  logic             w_stall;
  logic             w_adv;

  assign w_adv    = ~w_stall;
  assign in_ready = w_adv;

  for (genvar j = 0; j < LVL; j++) begin : g_lvl
    localparam int W   = IN_W + j + 1;
    localparam int N   = N_IN >> (j + 1);
    localparam int OFF = lvl_off(j);

    logic [2*N*(W-1)-1:0] w_src;
    logic                 w_src_vld;
    logic [N*W-1:0]       r_sum;
    logic                 r_vld;

    if (j == 0) begin : g_in
      assign w_src     = in_data;
      assign w_src_vld = in_valid;
    end else begin : g_prev
      assign w_src     = w_lvl[lvl_off(j-1) +: 2*N*(W-1)];
      assign w_src_vld = w_vld[j-1];
    end

    // Data moves with bubbles too; only the valid bit distinguishes them.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sum <= '0;
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_src_vld;
        for (int k = 0; k < N; k++) begin
          r_sum[k*W +: W] <= W'(w_src[2*k*(W-1) +: W-1]) +
                             W'(w_src[(2*k+1)*(W-1) +: W-1]);
        end
      end
    end

    assign w_lvl[OFF +: N*W] = r_sum;
    assign w_vld[j]          = r_vld;
  end

  assign w_tree_sum = w_lvl[LAST_OFF +: SUM_W];
  assign w_tree_vld = w_vld[LVL-1];

`ifdef ADDER_TREE_ACC_EN
  localparam int CNT_W = $clog2(ACC_N);

  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_vld;

  // The first result of a frame overwrites acc, so a frame can start in the
  // same cycle the previous frame's total is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= w_tree_vld && (r_cnt == CNT_W'(ACC_N - 1));
      if (w_tree_vld) begin
        r_acc <= (r_cnt == '0) ? OUT_W'(w_tree_sum) : r_acc + OUT_W'(w_tree_sum);
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_stall   = r_out_vld & ~out_ready;
  assign out_data  = r_acc;
  assign out_valid = r_out_vld;
  assign out_last  = r_out_vld;
`else
  assign w_stall   = w_tree_vld & ~out_ready;
  assign out_data  = w_tree_sum;
  assign out_valid = w_tree_vld;
  assign out_last  = w_tree_vld;
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: directed scenarios plus randomized traffic against a
// frame/delay-line reference model; follows whichever build ADDER_TREE_ACC_EN selects.
module tb_adder_tree_pipe;
  localparam int IN_W  = 14;
  localparam int N_IN  = 4;
  localparam int ACC_N = 8;
  localparam int LVL   = 2;
`ifdef ADDER_TREE_ACC_EN
  localparam int OUT_W = 19;
  localparam int F     = ACC_N;
  localparam int D     = LVL + 1;
`else
  localparam int OUT_W = 16;
  localparam int F     = 1;
  localparam int D     = LVL;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_IN*IN_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  adder_tree_pipe #(.IN_W(IN_W), .N_IN(N_IN), .ACC_N(ACC_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic longint opsum(input logic [N_IN*IN_W-1:0] d);
    longint s = 0;
    for (int k = 0; k < N_IN; k++) s += longint'(d[k*IN_W +: IN_W]);
    return s;
  endfunction

  function automatic logic [N_IN*IN_W-1:0] pk(input int a, input int b, input int c, input int d);
    return {14'(d), 14'(c), 14'(b), 14'(a)};
  endfunction

  // Reference model: each advancing cycle appends what the output must show D
  // advancing cycles later (-1 = nothing); results are grouped into frames of F.
  longint hist [4096];
  int     adv_n;
  int     fcnt;
  longint fsum;
  longint e_exp;
  logic   stall_exp;
  int     obs_cyc[$];
  longint obs_dat[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      adv_n = 0;
      fcnt  = 0;
      fsum  = 0;
    end else begin
      e_exp = (adv_n >= D) ? hist[adv_n - D] : -1;
      chk("out_valid", 64'(out_valid), 64'(e_exp >= 0));
      if (e_exp >= 0) begin
        chk("out_data", 64'(out_data), 64'(e_exp));
        chk("out_last", 64'(out_last), 64'd1);
      end else begin
        chk("out_last_idle", 64'(out_last), 64'd0);
      end
      stall_exp = (e_exp >= 0) && !out_ready;
      chk("in_ready", 64'(in_ready), 64'(!stall_exp));
      if (out_valid && out_ready) begin
        obs_cyc.push_back(cyc);
        obs_dat.push_back(longint'(out_data));
      end
      if (!stall_exp) begin
        hist[adv_n] = -1;
        if (in_valid) begin
          fsum += opsum(in_data);
          fcnt++;
          if (fcnt == F) begin
            hist[adv_n] = fsum;
            fsum = 0;
            fcnt = 0;
          end
        end
        adv_n++;
      end
    end
  end

  task automatic drive(input logic v, input logic [N_IN*IN_W-1:0] d);
    @(posedge clk); #1;
    in_valid = v;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_cyc.delete();
    obs_dat.delete();
  endtask

  int c0;

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

`ifndef ADDER_TREE_ACC_EN
    // Single full-scale operand set.
    clear_obs();
    drive(1'b1, pk(16383, 16383, 16383, 16383)); c0 = cyc;
    idle(5);
    chk("t1_count", 64'(obs_cyc.size()), 64'd1);
    if (obs_cyc.size() >= 1) begin
      chk("t1_latency", 64'(obs_cyc[0] - c0), 64'd2);
      chk("t1_data", 64'(obs_dat[0]), 64'd65532);
    end

    // Back-to-back inputs.
    clear_obs();
    drive(1'b1, pk(1, 2, 3, 4)); c0 = cyc;
    drive(1'b1, pk(10, 20, 30, 40));
    idle(5);
    chk("t2_count", 64'(obs_cyc.size()), 64'd2);
    if (obs_cyc.size() >= 2) begin
      chk("t2_first", 64'(obs_dat[0]), 64'd10);
      chk("t2_second", 64'(obs_dat[1]), 64'd100);
      chk("t2_first_cyc", 64'(obs_cyc[0] - c0), 64'd2);
      chk("t2_second_cyc", 64'(obs_cyc[1] - c0), 64'd3);
    end

    // Three stalled cycles while both results are in flight.
    clear_obs();
    drive(1'b1, pk(1, 2, 3, 4)); c0 = cyc;
    drive(1'b1, pk(10, 20, 30, 40));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t3_in_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data", 64'(out_data), 64'd10);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);
    chk("t3_count", 64'(obs_cyc.size()), 64'd2);
    if (obs_cyc.size() >= 2) begin
      chk("t3_first", 64'(obs_dat[0]), 64'd10);
      chk("t3_second", 64'(obs_dat[1]), 64'd100);
      chk("t3_first_cyc", 64'(obs_cyc[0] - c0), 64'd5);
      chk("t3_second_cyc", 64'(obs_cyc[1] - c0), 64'd6);
    end
`else
    // One frame of eight inputs summing to 10.
    clear_obs();
    repeat (8) drive(1'b1, pk(1, 2, 3, 4));
    c0 = cyc;
    idle(6);
    chk("t4_count", 64'(obs_cyc.size()), 64'd1);
    if (obs_cyc.size() >= 1) begin
      chk("t4_data", 64'(obs_dat[0]), 64'd80);
      chk("t4_latency", 64'(obs_cyc[0] - c0), 64'd3);
    end

    // Two full-scale frames back to back.
    clear_obs();
    repeat (16) drive(1'b1, pk(16383, 16383, 16383, 16383));
    idle(6);
    chk("t5_count", 64'(obs_cyc.size()), 64'd2);
    if (obs_cyc.size() >= 2) begin
      chk("t5_first", 64'(obs_dat[0]), 64'd524256);
      chk("t5_second", 64'(obs_dat[1]), 64'd524256);
      chk("t5_spacing", 64'(obs_cyc[1] - obs_cyc[0]), 64'd8);
    end
`endif

    // Reset after the 5th input of a frame, then a fresh frame of ones.
    repeat (5) drive(1'b1, pk(1, 2, 3, 4));
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_last", 64'(out_last), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    clear_obs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) drive(1'b1, pk(1, 0, 0, 0));
    c0 = cyc;
    idle(6);
`ifdef ADDER_TREE_ACC_EN
    chk("t6_count", 64'(obs_cyc.size()), 64'd1);
    if (obs_cyc.size() >= 1) begin
      chk("t6_data", 64'(obs_dat[0]), 64'd8);
      chk("t6_latency", 64'(obs_cyc[0] - c0), 64'd3);
    end
`else
    chk("t6_count", 64'(obs_cyc.size()), 64'd8);
    foreach (obs_dat[i]) chk("t6_data", 64'(obs_dat[i]), 64'd1);
`endif

    // Randomized traffic with backpressure; the model checks every cycle.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) in_data = pk(16383, 16383, 16383, 16383);
      else in_data = pk($urandom_range(0, 16383), $urandom_range(0, 16383),
                        $urandom_range(0, 16383), $urandom_range(0, 16383));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
